alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Decode-and-register stage that feeds the datapath ALU.
- Accepts a 32-bit RV32I instruction word and produces, one cycle later:
  - the 4-bit ALU command
  - register addresses
  - immediate and operand-select
  - an illegal flag
- Covers OP, OP-IMM and LUI.
- Single-entry pipeline register with valid/ready handshake on both sides, synchronous flush, and a saturating illegal-instruction counter.

Parameters:
REG_WIDTH, 32, datapath width; only 32 is supported.
CNT_WIDTH, 8, width of the illegal-instruction counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of the held entry and the current input
in_valid  input  1  instruction word valid
in_ready  output  1  stage can accept an instruction this cycle
in_inst  input  32  instruction word
out_valid  output  1  decoded entry valid
out_ready  input  1  downstream accepts the entry
out_alu_cmd  output  4  ADD 0000, SUB 0001, SLT 0010, SLTU 0011, AND 0100, OR 0101, XOR 0110, SLL 0111, SRL 1000, SRA 1001
out_rs1_addr  output  5  source register 1
out_rs2_addr  output  5  source register 2 (0 when use_imm)
out_rd_addr  output  5  destination register
out_imm  output  REG_WIDTH  immediate
out_use_imm  output  1  ALU operand 2 selects out_imm
out_illegal  output  1  instruction not decodable by this stage
illegal_count  output  CNT_WIDTH  illegal instructions accepted, saturating

Behaviour:
Reset:
- On rst assertion, asynchronously clear all state, independent of clk.
- All outputs are 0 during and after reset, including out_valid and illegal_count.
- Reset mid-transfer drops the held entry.

Handshake:
- in_ready = !flush && (!out_valid || out_ready). This is combinational and allows full throughput.
- Accept: in_valid && in_ready. The decoded result is registered at that edge, and out_valid=1 next cycle (latency 1).
- If out_valid && !out_ready, all out_* hold stable.
- If out_ready and no new accept, out_valid drops to 0 next cycle.
- Simultaneous pop and accept: the new entry replaces the old; out_valid stays 1.
- flush=1: out_valid <= 0. No accept occurs (in_ready=0), and illegal_count does not change. Flush has priority over everything except rst.
- Payload registers are don't-care when out_valid=0, but must not contain X after reset.

Decode rules (opcode = inst[6:0], f3 = inst[14:12], f7 = inst[31:25]):
- OP 0110011, f7=0000000:
  - f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- OP 0110011, f7=0100000:
  - f3 000 SUB, 101 SRA.
  - Any other f3/f7 combination is illegal.
- OP fields: use_imm=0, imm=0.
- OP-IMM 0010011:
  - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - imm = sign-extend inst[31:20]; use_imm=1; rs2_addr=0.
- OP-IMM shifts:
  - f3 001 needs f7=0000000 → SLL.
  - f3 101 with f7=0000000 → SRL; with f7=0100000 → SRA.
  - Shift imm = {27'b0, inst[24:20]}. Other f7 values are illegal.
- LUI 0110111:
  - cmd ADD, rs1_addr=0, rs2_addr=0, imm = {inst[31:12], 12'b0}, use_imm=1.
- rd_addr = inst[11:7] for all legal encodings.
- Illegal (any other opcode, or bad f7):
  - illegal=1, cmd ADD, all addresses 0, imm 0, use_imm 0.
  - The entry still flows through the handshake.

Illegal counter:
- Increments by 1 on each accepted illegal instruction.
- Saturates at 2^CNT_WIDTH-1; no wrap.
- Cleared only by rst.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2), out_ready=1 → next cycle out_valid=1, cmd 0000, rs1 1, rs2 2, rd 3, use_imm 0, illegal 0; out_valid=0 the following cycle.
- 0x40735293 (SRAI x5,x6,7) → cmd 1001, rs1 6, rd 5, imm 0x00000007, use_imm 1. Then 0xFFF00093 (ADDI x1,x0,-1) → cmd 0000, imm 0xFFFFFFFF.
- 0x123453B7 (LUI x7,0x12345) → cmd 0000, rs1 0, rd 7, imm 0x12345000, use_imm 1.
- Back-to-back stream of 4 instructions with out_ready=1 → 1 result per cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen, no accept. Release → held entry popped and next entry accepted in the same cycle.
- Illegal inputs:
  - 0x00000000 and 0x022081B3 (MUL) → illegal=1, cmd 0000, illegal_count 0→1→2.
  - 300 illegal instructions → count stops at 255.
- flush while out_valid=1 and in_valid=1 → out_valid=0 next cycle, in_ready=0 during flush, count unchanged.
- rst pulsed asynchronously between edges mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode-and-register stage for the ALU: OP, OP-IMM and LUI are decoded into
// an ALU command, register addresses and an immediate, then held in a one-entry pipeline register.
module alu_decode_stage #(
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_alu_cmd,
    output logic [4:0]           out_rs1_addr,
    output logic [4:0]           out_rs2_addr,
    output logic [4:0]           out_rd_addr,
    output logic [REG_WIDTH-1:0] out_imm,
    output logic                 out_use_imm,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0001;
    localparam logic [3:0] CMD_SLT  = 4'b0010;
    localparam logic [3:0] CMD_SLTU = 4'b0011;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_XOR  = 4'b0110;
    localparam logic [3:0] CMD_SLL  = 4'b0111;
    localparam logic [3:0] CMD_SRL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [3:0]           cmd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [REG_WIDTH-1:0] imm;
        logic                 use_imm;
        logic                 illegal;
    } dec_t;

    dec_t                 dec_d, dec_q;
    logic                 valid_d, valid_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 bad;
    logic                 accept;

    logic [6:0] opcode, f7;
    logic [2:0] f3;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    always_comb begin
        dec_d = '0;
        bad   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_d.rs1 = in_inst[19:15];
                dec_d.rs2 = in_inst[24:20];
                dec_d.rd  = in_inst[11:7];
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  dec_d.cmd = CMD_ADD;
                        3'b001:  dec_d.cmd = CMD_SLL;
                        3'b010:  dec_d.cmd = CMD_SLT;
                        3'b011:  dec_d.cmd = CMD_SLTU;
                        3'b100:  dec_d.cmd = CMD_XOR;
                        3'b101:  dec_d.cmd = CMD_SRL;
                        3'b110:  dec_d.cmd = CMD_OR;
                        default: dec_d.cmd = CMD_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec_d.cmd = CMD_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec_d.cmd = CMD_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_d.rs1     = in_inst[19:15];
                dec_d.rd      = in_inst[11:7];
                dec_d.use_imm = 1'b1;
                dec_d.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
                case (f3)
                    3'b000: dec_d.cmd = CMD_ADD;
                    3'b010: dec_d.cmd = CMD_SLT;
                    3'b011: dec_d.cmd = CMD_SLTU;
                    3'b100: dec_d.cmd = CMD_XOR;
                    3'b110: dec_d.cmd = CMD_OR;
                    3'b111: dec_d.cmd = CMD_AND;
                    // Shifts carry a 5-bit shamt; f7 picks logical vs arithmetic
                    3'b001: begin
                        dec_d.imm = {27'b0, in_inst[24:20]};
                        dec_d.cmd = CMD_SLL;
                        bad       = (f7 != F7_BASE);
                    end
                    default: begin
                        dec_d.imm = {27'b0, in_inst[24:20]};
                        if (f7 == F7_BASE)     dec_d.cmd = CMD_SRL;
                        else if (f7 == F7_ALT) dec_d.cmd = CMD_SRA;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_d.cmd     = CMD_ADD;
                dec_d.rd      = in_inst[11:7];
                dec_d.imm     = {in_inst[31:12], 12'b0};
                dec_d.use_imm = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec_d         = '0;
            dec_d.illegal = 1'b1;
        end
    end

    assign in_ready = !rst && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
        if (accept && dec_d.illegal && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (accept) dec_q <= dec_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_alu_cmd   = dec_q.cmd;
    assign out_rs1_addr  = dec_q.rs1;
    assign out_rs2_addr  = dec_q.rs2;
    assign out_rd_addr   = dec_q.rd;
    assign out_imm       = dec_q.imm;
    assign out_use_imm   = dec_q.use_imm;
    assign out_illegal   = dec_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: hand-computed decode results, handshake,
// backpressure, flush, counter saturation and asynchronous reset.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, out_imm;
    logic [3:0]  out_alu_cmd;
    logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic        out_use_imm, out_illegal;
    logic [7:0]  illegal_count;

    int passed = 0;
    int total  = 0;

    alu_decode_stage #(.REG_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_cmd(out_alu_cmd), .out_rs1_addr(out_rs1_addr),
        .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic [3:0] cmd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                           input logic use_imm, input logic ill);
        chk({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        chk({tag, ".cmd"},     {28'b0, out_alu_cmd}, {28'b0, cmd});
        chk({tag, ".rs1"},     {27'b0, out_rs1_addr}, {27'b0, rs1});
        chk({tag, ".rs2"},     {27'b0, out_rs2_addr}, {27'b0, rs2});
        chk({tag, ".rd"},      {27'b0, out_rd_addr}, {27'b0, rd});
        chk({tag, ".imm"},     out_imm, imm);
        chk({tag, ".use_imm"}, {31'b0, out_use_imm}, {31'b0, use_imm});
        chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".cmd"},   {28'b0, out_alu_cmd}, 32'd0);
        chk({tag, ".addr"},  {17'b0, out_rs1_addr, out_rs2_addr, out_rd_addr}, 32'd0);
        chk({tag, ".imm"},   out_imm, 32'd0);
        chk({tag, ".flags"}, {30'b0, out_use_imm, out_illegal}, 32'd0);
        chk({tag, ".count"}, {24'b0, illegal_count}, 32'd0);
    endtask

    logic [31:0] stream [4];
    logic [3:0]  stream_cmd [4];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
        #1;
        chk_zero("reset");
        @(posedge clk); #3; rst = 1'b0;
        tick();
        chk("post_reset_ready", {31'b0, in_ready}, 32'd1);

        // ADD x3,x1,x2
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h002081B3;
        tick(); in_valid = 1'b0;
        chk_dec("add", 4'b0000, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0);
        tick();
        chk("add_drain", {31'b0, out_valid}, 32'd0);

        // SRAI x5,x6,7 then ADDI x1,x0,-1 back to back
        in_valid = 1'b1; in_inst = 32'h40735293;
        tick();
        chk_dec("srai", 4'b1001, 5'd6, 5'd0, 5'd5, 32'h7, 1'b1, 1'b0);
        in_inst = 32'hFFF00093;
        tick();
        chk_dec("addi", 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0);

        // LUI x7,0x12345
        in_inst = 32'h123453B7;
        tick();
        chk_dec("lui", 4'b0000, 5'd0, 5'd0, 5'd7, 32'h12345000, 1'b1, 1'b0);

        // Full-throughput stream: SUB, AND, OR, SLTU on x3,x1,x2
        stream[0] = 32'h402081B3; stream_cmd[0] = 4'b0001;
        stream[1] = 32'h0020F1B3; stream_cmd[1] = 4'b0100;
        stream[2] = 32'h0020E1B3; stream_cmd[2] = 4'b0101;
        stream[3] = 32'h0020B1B3; stream_cmd[3] = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            in_inst = stream[i];
            chk($sformatf("stream%0d_ready", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("stream%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stream%0d_cmd", i), {28'b0, out_alu_cmd}, {28'b0, stream_cmd[i]});
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'b0, out_valid}, 32'd0);

        // Backpressure: XOR held while SLL waits
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0020C1B3;
        tick();
        chk_dec("bp_xor", 4'b0110, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0);
        in_inst = 32'h002091B3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_ready", i), {31'b0, in_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_cmd", i), {28'b0, out_alu_cmd}, 32'd6);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk_dec("bp_sll", 4'b0111, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", {31'b0, out_valid}, 32'd0);

        // Illegal encodings: zero word, MUL, SLLI with bad f7
        in_valid = 1'b1; in_inst = 32'h00000000;
        tick();
        chk_dec("ill_zero", 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("ill_zero_cnt", {24'b0, illegal_count}, 32'd1);
        in_inst = 32'h022081B3;
        tick();
        chk_dec("ill_mul", 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("ill_mul_cnt", {24'b0, illegal_count}, 32'd2);
        in_inst = 32'h40109093;
        tick();
        chk_dec("ill_slli", 4'b0000, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
        chk("ill_slli_cnt", {24'b0, illegal_count}, 32'd3);

        // Flush with a held entry and an illegal word on the input
        in_inst = 32'h002081B3;
        tick();
        chk("pre_flush_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b0; flush = 1'b1; in_inst = 32'h00000000;
        #1;
        chk("flush_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_cnt", {24'b0, illegal_count}, 32'd3);
        flush = 1'b0; out_ready = 1'b1;

        // Saturation: 300 more illegal words
        for (int i = 0; i < 252; i++) tick();
        chk("sat_255", {24'b0, illegal_count}, 32'd255);
        for (int i = 0; i < 48; i++) tick();
        chk("sat_hold", {24'b0, illegal_count}, 32'd255);
        chk("sat_valid", {31'b0, out_valid}, 32'd1);

        // Asynchronous reset between edges mid-stream
        in_inst = 32'h123453B7;
        tick();
        chk("pre_rst_imm", out_imm, 32'h12345000);
        #2; rst = 1'b1; in_valid = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("async_rst_ready", {31'b0, in_ready}, 32'd0);
        #2; rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_cnt", {24'b0, illegal_count}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
